uart_fifo_bridge: RTL and testbench

UART_FIFO_BRIDGE -- requirements
Module: uart_fifo_bridge

---
 rtl/uart_fifo_bridge_if.sv | 42 ++++
 rtl/uart_fifo_bridge.sv | 188 ++++++++++++++++++
 tb/tb_uart_fifo_bridge.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_fifo_bridge_if.sv
// ---------------------------------------------------------------------------
// uart_fifo_bridge_if
// CPU register bus for uart_fifo_bridge.
//
// Signals:
//   io_wr    : write strobe; the access happens in every cycle it is 1
//   io_rd    : read strobe; the access happens in every cycle it is 1
//   io_addr  : register select (0 DATA, 1 STATUS, 2 CTRL, 3 reserved)
//   io_wdata : write data, qualified by io_wr
//   io_rdata : registered read data, valid the cycle after io_rd, held
//              until the next io_rd
//
// Handshake: strobe semantics with no backpressure. Each cycle with io_wr
// or io_rd high is exactly one accepted access (the bridge is always
// ready). When both strobes are high in the same cycle the read wins and
// the write is dropped.
//
// Modports: master = CPU side, slave = bridge side.
// ---------------------------------------------------------------------------
interface uart_fifo_bridge_if;
  logic        io_wr;
  logic        io_rd;
  logic [1:0]  io_addr;
  logic [7:0]  io_wdata;
  logic [31:0] io_rdata;

  modport master (
    output io_wr,
    output io_rd,
    output io_addr,
    output io_wdata,
    input  io_rdata
  );

  modport slave (
    input  io_wr,
    input  io_rd,
    input  io_addr,
    input  io_wdata,
    output io_rdata
  );
endinterface

// File: rtl/uart_fifo_bridge.sv
// ---------------------------------------------------------------------------
// uart_fifo_bridge
// Couples a CPU register bus to a byte UART through a TX FIFO and an RX FIFO
// (DEPTH x 8 each). A TX drain FSM feeds the transmitter one byte at a time;
// an RX capture FSM acknowledges and stores received bytes.
//
// Optional feature macro: UART_FIFO_IRQ_EN (level interrupt + CTRL bit1
// tx_irq_enable). Without it irq is tied low and CTRL bit1 reads 0.
//
// Ports:
//   clk, reset      : single clock, synchronous active-high reset
//   cpu             : CPU register bus (uart_fifo_bridge_if.slave)
//   uart_wr         : one-cycle TX byte strobe
//   uart_tx_data    : TX byte, holds the last byte sent while uart_wr = 0
//   uart_busy       : transmitter busy
//   uart_rd         : one-cycle RX acknowledge
//   uart_rx_data    : received byte
//   uart_valid      : received byte pending
//   irq             : level interrupt request
//   o_dbg_tx_state  : TX FSM state (debug)
//   o_dbg_rx_state  : RX FSM state (debug)
// ---------------------------------------------------------------------------
module uart_fifo_bridge #(
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  uart_fifo_bridge_if.slave       cpu,
  output logic                    uart_wr,
  output logic [7:0]              uart_tx_data,
  input  logic                    uart_busy,
  output logic                    uart_rd,
  input  logic [7:0]              uart_rx_data,
  input  logic                    uart_valid,
  output logic                    irq,
  output logic [1:0]              o_dbg_tx_state,
  output logic                    o_dbg_rx_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_SEND  = 2'd1;
  localparam logic [1:0] TX_GUARD = 2'd2;
  localparam logic [0:0] RX_IDLE  = 1'b0;
  localparam logic [0:0] RX_ACK   = 1'b1;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  logic [7:0]  r_tx_mem [DEPTH];
  logic [7:0]  r_rx_mem [DEPTH];
  logic [AW:0] r_tx_wptr, r_tx_rptr, r_rx_wptr, r_rx_rptr;
  logic [1:0]  r_tx_state;
  logic [0:0]  r_rx_state;
  logic [7:0]  r_tx_data;
  logic [31:0] r_rdata;
  logic        r_rx_ovf;

  logic        w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
  logic        w_cpu_wr, w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
  logic        w_rx_req, w_rx_drop, w_ovf_clr, w_tx_cz;
  logic [7:0]  w_tx_head, w_rx_head, w_status, w_ctrl_rd;
  logic [31:0] w_rd_mux;

  // Extra MSB on the pointers tells full (MSBs differ) from empty (equal).
  assign w_tx_empty = (r_tx_wptr == r_tx_rptr);
  assign w_tx_full  = (r_tx_wptr[AW] != r_tx_rptr[AW]) &&
                      (r_tx_wptr[AW-1:0] == r_tx_rptr[AW-1:0]);
  assign w_rx_empty = (r_rx_wptr == r_rx_rptr);
  assign w_rx_full  = (r_rx_wptr[AW] != r_rx_rptr[AW]) &&
                      (r_rx_wptr[AW-1:0] == r_rx_rptr[AW-1:0]);

  assign w_tx_head = r_tx_mem[r_tx_rptr[AW-1:0]];
  assign w_rx_head = r_rx_mem[r_rx_rptr[AW-1:0]];

  // A read in the same cycle suppresses the write (single shared address).
  assign w_cpu_wr  = cpu.io_wr && !cpu.io_rd;

  assign w_tx_pop  = (r_tx_state == TX_SEND) && !w_tx_empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO lands.
  assign w_tx_push = w_cpu_wr && (cpu.io_addr == ADDR_DATA) &&
                     (!w_tx_full || w_tx_pop);

  assign w_rx_pop  = cpu.io_rd && (cpu.io_addr == ADDR_DATA) && !w_rx_empty;
  assign w_rx_req  = (r_rx_state == RX_IDLE) && uart_valid && !reset;
  assign w_rx_push = w_rx_req && (!w_rx_full || w_rx_pop);
  assign w_rx_drop = w_rx_req && !w_rx_push;
  assign w_ovf_clr = w_cpu_wr && (cpu.io_addr == ADDR_CTRL) && cpu.io_wdata[0];

  // Transmitter counts as idle only when the FSM has finished its guard cycle.
  assign w_tx_cz   = w_tx_empty && !uart_busy && (r_tx_state == TX_IDLE);
  assign w_status  = {2'b00, w_tx_cz, r_rx_ovf, w_tx_full, w_tx_empty,
                      w_rx_full, w_rx_empty};

  always_comb begin
    w_rd_mux = 32'h0;
    case (cpu.io_addr)
      ADDR_DATA:   w_rd_mux = w_rx_empty ? 32'h0 : {24'h0, w_rx_head};
      ADDR_STATUS: w_rd_mux = {24'h0, w_status};
      ADDR_CTRL:   w_rd_mux = {24'h0, w_ctrl_rd};
      default:     w_rd_mux = 32'h0;
    endcase
  end

  // FIFO storage keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr[AW-1:0]] <= cpu.io_wdata;
    if (w_rx_push) r_rx_mem[r_rx_wptr[AW-1:0]] <= uart_rx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_wptr  <= '0;
      r_tx_rptr  <= '0;
      r_rx_wptr  <= '0;
      r_rx_rptr  <= '0;
      r_tx_state <= TX_IDLE;
      r_rx_state <= RX_IDLE;
      r_tx_data  <= 8'h00;
      r_rdata    <= 32'h0;
      r_rx_ovf   <= 1'b0;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + PTR_ONE;
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + PTR_ONE;
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + PTR_ONE;
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + PTR_ONE;

      if (cpu.io_rd) r_rdata <= w_rd_mux;

      // Clear wins over a drop landing in the same cycle.
      if (w_ovf_clr)      r_rx_ovf <= 1'b0;
      else if (w_rx_drop) r_rx_ovf <= 1'b1;

      case (r_tx_state)
        TX_IDLE: begin
          if (!w_tx_empty && !uart_busy) begin
            r_tx_state <= TX_SEND;
            // Latch the head now; it stays on uart_tx_data after the pulse.
            r_tx_data  <= w_tx_head;
          end
        end
        TX_SEND:  r_tx_state <= TX_GUARD;
        // Gives the transmitter a cycle to raise uart_busy.
        TX_GUARD: r_tx_state <= TX_IDLE;
        default:  r_tx_state <= TX_IDLE;
      endcase

      case (r_rx_state)
        RX_IDLE: if (uart_valid) r_rx_state <= RX_ACK;
        RX_ACK:  r_rx_state <= RX_IDLE;
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

`ifdef UART_FIFO_IRQ_EN
  logic r_tx_irq_en;
  logic r_irq;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_irq_en <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      if (w_cpu_wr && (cpu.io_addr == ADDR_CTRL)) r_tx_irq_en <= cpu.io_wdata[1];
      r_irq <= !w_rx_empty || r_rx_ovf || (w_tx_empty && r_tx_irq_en);
    end
  end

  assign w_ctrl_rd = {6'b0, r_tx_irq_en, 1'b0};
  assign irq       = r_irq;
`else
  assign w_ctrl_rd = 8'h00;
  assign irq       = 1'b0;
`endif

  assign uart_wr        = (r_tx_state == TX_SEND);
  assign uart_tx_data   = r_tx_data;
  // Mealy acknowledge: same cycle as the push, never during reset.
  assign uart_rd        = w_rx_req;
  assign cpu.io_rdata   = r_rdata;
  assign o_dbg_tx_state = r_tx_state;
  assign o_dbg_rx_state = r_rx_state[0];

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// ---------------------------------------------------------------------------
// tb_uart_fifo_bridge
// Directed bench for uart_fifo_bridge (DEPTH = 16). A small transmitter
// model raises uart_busy for a few cycles after each uart_wr pulse; a
// negedge monitor collects sent bytes and acknowledge pulses.
// ---------------------------------------------------------------------------
module tb_uart_fifo_bridge;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       uart_wr, uart_rd, irq, uart_busy;
  logic       uart_valid;
  logic [7:0] uart_tx_data, uart_rx_data;
  logic [1:0] dbg_tx_state;
  logic       dbg_rx_state;

  logic       hold_busy = 1'b0;
  int         busy_cnt = 0;
  logic       busy_prev = 1'b0;
  int         pulse_cnt = 0;
  int         busy_viol = 0;
  int         rd_cnt = 0;

  int         n_checks = 0;
  int         n_pass = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  uart_fifo_bridge_if cpu_if();

  uart_fifo_bridge #(.DEPTH(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .cpu            (cpu_if),
    .uart_wr        (uart_wr),
    .uart_tx_data   (uart_tx_data),
    .uart_busy      (uart_busy),
    .uart_rd        (uart_rd),
    .uart_rx_data   (uart_rx_data),
    .uart_valid     (uart_valid),
    .irq            (irq),
    .o_dbg_tx_state (dbg_tx_state),
    .o_dbg_rx_state (dbg_rx_state)
  );

  // ---- clock ----
  always #5 clk = ~clk;

  // ---- transmitter model: busy for 3 cycles after each strobe ----
  assign uart_busy = hold_busy || (busy_cnt != 0);

  always @(posedge clk) begin
    #1;
    if (uart_wr) busy_cnt = 3;
    else if (busy_cnt != 0) busy_cnt = busy_cnt - 1;
  end

  // ---- monitor ----
  always @(negedge clk) begin
    if (uart_wr) begin
      got_q.push_back(uart_tx_data);
      pulse_cnt = pulse_cnt + 1;
      if (busy_prev) busy_viol = busy_viol + 1;
    end
    if (uart_rd) rd_cnt = rd_cnt + 1;
    busy_prev = uart_busy;
  end

  // ---- driver tasks ----
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass = n_pass + 1;
  endtask

  task automatic cpu_write(input logic [1:0] addr, input logic [7:0] data);
    cpu_if.io_wr    = 1'b1;
    cpu_if.io_addr  = addr;
    cpu_if.io_wdata = data;
    tick();
    cpu_if.io_wr    = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] addr, output logic [31:0] d);
    cpu_if.io_rd   = 1'b1;
    cpu_if.io_addr = addr;
    tick();
    cpu_if.io_rd   = 1'b0;
    d = cpu_if.io_rdata;
  endtask

  task automatic send_rx(input logic [7:0] b);
    uart_valid   = 1'b1;
    uart_rx_data = b;
    tick();
    uart_valid   = 1'b0;
    tick();
  endtask

  task automatic wait_pulses(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (pulse_cnt >= n) break;
      tick();
    end
  endtask

  // ---- scoreboard: sent bytes against the expected queue ----
  task automatic check_tx(input string tag);
    logic [7:0]  e;
    logic [31:0] g;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() > 0) g = {24'h0, got_q.pop_front()};
      else g = 32'hFFFF_FFFF;
      check(tag, g, {24'h0, e});
    end
    check({tag, "_extra"}, got_q.size(), 0);
    got_q.delete();
  endtask

  // ---- stimulus ----
  initial begin
    logic [31:0] d;

    cpu_if.io_wr    = 1'b0;
    cpu_if.io_rd    = 1'b0;
    cpu_if.io_addr  = 2'd0;
    cpu_if.io_wdata = 8'h00;
    uart_valid      = 1'b0;
    uart_rx_data    = 8'h00;

    repeat (3) tick();
    reset = 1'b0;

    // reset state
    check("rst_uart_wr", uart_wr, 0);
    check("rst_uart_rd", uart_rd, 0);
    check("rst_tx_data", uart_tx_data, 0);
    check("rst_rdata", cpu_if.io_rdata, 0);
    check("rst_irq", irq, 0);
    check("rst_tx_state", dbg_tx_state, 0);
    cpu_read(2'd1, d);
    check("rst_status", d, 32'h25);

    // two bytes, second waits for busy to fall
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    cpu_write(2'd0, 8'h41);
    cpu_write(2'd0, 8'h42);
    wait_pulses(2, 60);
    repeat (8) tick();
    check("t1_pulses", pulse_cnt, 2);
    check("t1_busy_viol", busy_viol, 0);
    check("t1_tx_hold", uart_tx_data, 8'h42);
    check_tx("t1_byte");
    cpu_read(2'd1, d);
    check("t1_status", d, 32'h25);

    // TX full: 17 writes with busy held, 16 drained
    pulse_cnt = 0;
    hold_busy = 1'b1;
    for (int i = 0; i < 17; i++) cpu_write(2'd0, 8'h10 + 8'(i));
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h10 + 8'(i));
    tick();
    check("t2_no_pulse_busy", pulse_cnt, 0);
    cpu_read(2'd1, d);
    check("t2_status_full", d, 32'h09);
    hold_busy = 1'b0;
    wait_pulses(16, 400);
    repeat (20) tick();
    check("t2_pulses", pulse_cnt, 16);
    check("t2_busy_viol", busy_viol, 0);
    check_tx("t2_byte");

    // uart_valid held for two cycles
    rd_cnt = 0;
    uart_valid   = 1'b1;
    uart_rx_data = 8'h5A;
    tick();
    tick();
    uart_valid   = 1'b0;
    tick();
    check("t3_rd_pulses", rd_cnt, 1);
    cpu_read(2'd0, d);
    check("t3_data", d, 32'h0000005A);
    cpu_read(2'd1, d);
    check("t3_status", d, 32'h25);
    cpu_read(2'd0, d);
    check("t3_empty_read", d, 32'h0);

    // RX overflow with 17 bytes
    for (int i = 0; i < 17; i++) send_rx(8'h80 + 8'(i));
    cpu_read(2'd1, d);
    check("t4_status_ovf", d, 32'h36);
    for (int i = 0; i < 16; i++) begin
      cpu_read(2'd0, d);
      check("t4_data", d, 32'h80 + 32'(i));
    end
    cpu_read(2'd1, d);
    check("t4_status_sticky", d, 32'h35);
    cpu_write(2'd2, 8'h01);
    cpu_read(2'd1, d);
    check("t4_status_clr", d, 32'h25);

    // RX full, pop and push in the same cycle
    for (int i = 0; i < 16; i++) send_rx(8'hA0 + 8'(i));
    uart_valid     = 1'b1;
    uart_rx_data   = 8'hC3;
    cpu_if.io_rd   = 1'b1;
    cpu_if.io_addr = 2'd0;
    tick();
    cpu_if.io_rd   = 1'b0;
    uart_valid     = 1'b0;
    d = cpu_if.io_rdata;
    tick();
    check("t5_oldest", d, 32'hA0);
    cpu_read(2'd1, d);
    check("t5_status", d, 32'h26);
    for (int i = 1; i < 16; i++) begin
      cpu_read(2'd0, d);
      check("t5_data", d, 32'hA0 + 32'(i));
    end
    cpu_read(2'd0, d);
    check("t5_new_byte", d, 32'hC3);

    // overflow clear wins over a drop in the same cycle
    for (int i = 0; i < 16; i++) send_rx(8'(i));
    uart_valid      = 1'b1;
    uart_rx_data    = 8'hEE;
    cpu_if.io_wr    = 1'b1;
    cpu_if.io_addr  = 2'd2;
    cpu_if.io_wdata = 8'h01;
    tick();
    cpu_if.io_wr    = 1'b0;
    uart_valid      = 1'b0;
    tick();
    cpu_read(2'd1, d);
    check("t6_clr_priority", d, 32'h26);
    send_rx(8'hEF);
    cpu_read(2'd1, d);
    check("t6_ovf_recur", d, 32'h36);

    // reset with five bytes queued in TX
    pulse_cnt = 0;
    hold_busy = 1'b1;
    for (int i = 0; i < 5; i++) cpu_write(2'd0, 8'h60 + 8'(i));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    hold_busy = 1'b0;
    check("t7_rdata_rst", cpu_if.io_rdata, 0);
    check("t7_irq_rst", irq, 0);
    cpu_read(2'd1, d);
    check("t7_status", d, 32'h25);
    repeat (20) tick();
    check("t7_no_pulses", pulse_cnt, 0);
    got_q.delete();

    // write and read together: write dropped, read honoured
    cpu_if.io_wr    = 1'b1;
    cpu_if.io_rd    = 1'b1;
    cpu_if.io_addr  = 2'd0;
    cpu_if.io_wdata = 8'h99;
    tick();
    cpu_if.io_wr    = 1'b0;
    cpu_if.io_rd    = 1'b0;
    check("t8_read_empty", cpu_if.io_rdata, 0);
    repeat (10) tick();
    check("t8_no_pulse", pulse_cnt, 0);
    cpu_read(2'd1, d);
    check("t8_status", d, 32'h25);

    // interrupt
    send_rx(8'h77);
`ifdef UART_FIFO_IRQ_EN
    check("t9_irq_rx", irq, 1);
`else
    check("t9_irq_rx", irq, 0);
`endif
    cpu_read(2'd0, d);
    check("t9_data", d, 32'h77);
    tick();
    check("t9_irq_popped", irq, 0);
    cpu_write(2'd2, 8'h03);
    tick();
    cpu_read(2'd2, d);
`ifdef UART_FIFO_IRQ_EN
    check("t9_ctrl_rd", d, 32'h2);
    check("t9_irq_txen", irq, 1);
`else
    check("t9_ctrl_rd", d, 32'h0);
    check("t9_irq_txen", irq, 0);
`endif
    cpu_read(2'd3, d);
    check("t9_addr3", d, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
